rf_write_queue: RTL and testbench

- Write-back buffer directly upstream of the 16 x 32-bit register file.
- Accepts register-write results from two producers, the ALU and the load unit, and queues them in order.
- Drains one write per cycle into the register file's write port: load enable, 4-bit destination select, 32-bit data.
- Optionally forwards pending (not yet written) values to the two read-port addresses so operand fetch does not read stale data.

---
 rtl/rf_write_queue_if.sv | 45 ++++
 rtl/rf_write_queue.sv | 100 ++++++++++
 tb/tb_rf_write_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_queue_if.sv
// Bundle between the write-back queue, its two producers, the register file
// write port and the operand-fetch read addresses.
interface rf_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_stall;
  logic              rf_ld;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              fwd_hit_a;
  logic [DATA_W-1:0] fwd_data_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_b;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           rf_stall, rd_addr_a, rd_addr_b,
    input  alu_ready, mem_ready, rf_ld, rf_addr, rf_data,
           fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, count, full, empty
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           rf_stall, rd_addr_a, rd_addr_b,
    output alu_ready, mem_ready, rf_ld, rf_addr, rf_data,
           fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b, count, full, empty
  );
endinterface

// File: rtl/rf_write_queue.sv
// In-order write-back queue feeding the register file write port.
// Define RF_FWD_EN to enable forwarding of pending writes to the read ports.
module rf_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  rf_write_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // Handshake: a producer transfers on valid && ready at the rising edge;
  // ready depends only on full (and mem_valid for the ALU), never on a pop.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;

  assign push      = (bus.mem_valid || bus.alu_valid) && !full;
  assign push_addr = bus.mem_valid ? bus.mem_addr : bus.alu_addr;
  assign push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
  assign pop       = !empty && !bus.rf_stall;

  assign bus.rf_ld   = pop;
  assign bus.rf_addr = empty ? '0 : addr_mem[head];
  assign bus.rf_data = empty ? '0 : data_mem[head];
  assign bus.count   = cnt;
  assign bus.full    = full;
  assign bus.empty   = empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        addr_mem[tail] <= push_addr;
        data_mem[tail] <= push_data;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef RF_FWD_EN
  logic [PTR_W-1:0] idx;

  // Scan from head to tail so the youngest matching entry overrides older ones.
  always_comb begin
    bus.fwd_hit_a  = 1'b0;
    bus.fwd_data_a = '0;
    bus.fwd_hit_b  = 1'b0;
    bus.fwd_data_b = '0;
    idx            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < cnt) begin
        if (addr_mem[idx] == bus.rd_addr_a) begin
          bus.fwd_hit_a  = 1'b1;
          bus.fwd_data_a = data_mem[idx];
        end
        if (addr_mem[idx] == bus.rd_addr_b) begin
          bus.fwd_hit_b  = 1'b1;
          bus.fwd_data_b = data_mem[idx];
        end
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{bus.rd_addr_a, bus.rd_addr_b};
  assign bus.fwd_hit_a  = 1'b0;
  assign bus.fwd_data_a = '0;
  assign bus.fwd_hit_b  = 1'b0;
  assign bus.fwd_data_b = '0;
`endif
endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue; a negedge monitor tracks accepted writes
// in an expected queue and checks every register-file write against it.
module tb_rf_write_queue;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [35:0] exp_q[$];
  logic        acc;

  rf_write_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) bus ();

  rf_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: record accepted writes, compare each rf write with the oldest.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.rf_ld) begin
        if (exp_q.size() == 0) begin
          check("rf_ld_unexpected", 32'(bus.rf_addr), 32'hFFFF_FFFF);
        end else begin
          check("rf_addr_order", 32'(bus.rf_addr), 32'(exp_q[0][35:32]));
          check("rf_data_order", bus.rf_data, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
      end
      check("count_max", 32'(bus.count <= 3'd4), 32'd1);
      if (bus.mem_valid && bus.mem_ready)
        exp_q.push_back({bus.mem_addr, bus.mem_data});
      else if (bus.alu_valid && bus.alu_ready)
        exp_q.push_back({bus.alu_addr, bus.alu_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.rf_stall  = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_rf_ld", 32'(bus.rf_ld), 32'd0);
    check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    check("rst_rf_data", bus.rf_data, 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);

    // Single ALU write: visible on rf_ld the cycle after acceptance.
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'hAA;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("single_rf_ld", 32'(bus.rf_ld), 32'd1);
    check("single_rf_addr", 32'(bus.rf_addr), 32'd3);
    check("single_rf_data", bus.rf_data, 32'hAA);
    check("single_count", 32'(bus.count), 32'd1);
    tick();
    #1;
    check("single_empty", 32'(bus.empty), 32'd1);
    check("single_rf_ld_off", 32'(bus.rf_ld), 32'd0);

    // Both producers at once: mem wins, ALU follows.
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd5; bus.mem_data = 32'h55;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd6; bus.alu_data = 32'h66;
    #1;
    check("prio_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("prio_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    check("prio_alu_ready2", 32'(bus.alu_ready), 32'd1);
    check("prio_rf_addr5", 32'(bus.rf_addr), 32'd5);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("prio_rf_addr6", 32'(bus.rf_addr), 32'd6);
    check("prio_rf_data6", bus.rf_data, 32'h66);
    tick();
    #1;
    check("prio_empty", 32'(bus.empty), 32'd1);

    // Fill under stall, hold a fifth write, then drain.
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1; bus.mem_addr = 4'(8 + i); bus.mem_data = 32'h100 + 32'(i);
      tick();
    end
    bus.mem_addr = 4'd12; bus.mem_data = 32'h104;
    #1;
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("fill_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("fill_rf_ld", 32'(bus.rf_ld), 32'd0);
    tick();
    #1;
    check("fill_held_count", 32'(bus.count), 32'd4);
    bus.rf_stall = 1'b0;
    #1;
    check("drain_addr8", 32'(bus.rf_addr), 32'd8);
    tick();
    #1;
    check("drain_count3", 32'(bus.count), 32'd3);
    check("drain_ready_back", 32'(bus.mem_ready), 32'd1);
    check("drain_addr9", 32'(bus.rf_addr), 32'd9);
    tick();
    bus.mem_valid = 1'b0;
    #1;
    check("drain_count3b", 32'(bus.count), 32'd3);
    check("drain_addr10", 32'(bus.rf_addr), 32'd10);
    tick();
    tick();
    #1;
    check("drain_addr12", 32'(bus.rf_addr), 32'd12);
    check("drain_data12", bus.rf_data, 32'h104);
    tick();
    #1;
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Wrap: seven writes with alternating stall; monitor checks order.
    for (int k = 0; k < 7; k++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 4'(k); bus.alu_data = 32'h200 + 32'(k);
      bus.rf_stall  = k[0];
      for (int t = 0; t < 20; t++) begin
        #1;
        acc = bus.alu_ready;
        tick();
        if (acc) break;
      end
    end
    bus.alu_valid = 1'b0;
    bus.rf_stall  = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    #1;
    check("wrap_empty", 32'(bus.empty), 32'd1);
    check("wrap_sb_drained", 32'(exp_q.size()), 32'd0);

    // Forwarding: two pending writes to r2, youngest wins.
    bus.rf_stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 32'h11;
    tick();
    bus.alu_data = 32'h22;
    tick();
    bus.alu_valid = 1'b0;
    bus.rd_addr_a = 4'd2; bus.rd_addr_b = 4'd7;
    #1;
`ifdef RF_FWD_EN
    check("fwd_hit_a", 32'(bus.fwd_hit_a), 32'd1);
    check("fwd_data_a", bus.fwd_data_a, 32'h22);
    check("fwd_hit_b", 32'(bus.fwd_hit_b), 32'd0);
`else
    check("fwd_hit_a_off", 32'(bus.fwd_hit_a), 32'd0);
    check("fwd_data_a_off", bus.fwd_data_a, 32'd0);
    check("fwd_hit_b_off", 32'(bus.fwd_hit_b), 32'd0);
`endif

    // Reset with three pending: flushed, and it wins over a concurrent push/pop.
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("pend_count", 32'(bus.count), 32'd3);
    reset = 1'b1;
    bus.rf_stall  = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd9; bus.mem_data = 32'h99;
    tick();
    reset = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_rf_ld", 32'(bus.rf_ld), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    for (int t = 0; t < 3; t++) begin
      tick();
      #1;
      check("flush_no_stale", 32'(bus.rf_ld), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
